llr_frame_loader: RTL
=====================

// Module: llr_frame_loader
// PURPOSE
//  Parametrised input deserialiser for the min-sum decoder datapath. Collects one codeword's
//  N_V channel LLRs, arriving N_LLRS per beat, into a full frame; presents it with hard decisions
//  to the decoder core over a valid/ready handshake. Ping-pong buffering: a new frame may load while
//  the previous one waits for the core. Supports any N_V/N_LLRS ratio, including N_LLRS >= N_V.
// PARAMETERS
//  WIDTH   8   bits per LLR, two's complement
//  N_LLRS  4   LLRs per input beat (lanes)
//  N_V     31  LLRs per frame (variable nodes)
//  derived: N_CHUNKS = ceil(N_V/N_LLRS); LAST_LANES = N_V - (N_CHUNKS-1)*N_LLRS
// PORTS
//  clk          in   1               clock, rising edge
//  rst          in   1               asynchronous, active-high reset
//  in_llr       in   N_LLRS*WIDTH    lane j at [j*WIDTH +: WIDTH]
//  in_first     in   1               beat is chunk 0 of a frame
//  in_valid     in   1               beat valid
//  in_ready     out  1               loader accepts beat; handshake = in_valid & in_ready
//  frame_llrs   out  N_V*WIDTH       LLR i at [i*WIDTH +: WIDTH]
//  hard_dec     out  N_V             bit i = sign bit of LLR i (1 = negative)
//  frame_valid  out  1               output frame valid
//  frame_ready  in   1               core takes frame; transfer = frame_valid & frame_ready
//  frame_err    out  1               one-cycle pulse on protocol error
// BEHAVIOUR
//  - Single clock domain. rst asynchronous active-high: state=IDLE, chunk counter=0, assembly and
//    output registers=0, frame_valid=0, frame_err=0, hard_dec=0, frame_llrs=0, immediately on assert.
//  - in_ready is combinational from state: 1 in IDLE and LOAD, 0 in HOLD (so 1 right after reset).
//  - Mapping: accepted chunk k, lane j -> LLR k*N_LLRS+j. Last-chunk lanes >= LAST_LANES ignored.
//  - FSM:
//    IDLE: beat with in_first -> store chunk 0, cnt=1, go LOAD (or complete if N_CHUNKS==1).
//          beat without in_first -> discarded, frame_err pulse, stay IDLE.
//    LOAD: beat without in_first -> store chunk cnt, cnt+1. Beat with cnt==N_CHUNKS-1 completes frame.
//          beat with in_first -> abort partial frame, frame_err pulse, restart as chunk 0 (cnt=1).
//    Completion: if output register free (frame_valid==0, or output transfer in same cycle), the
//          merged frame (assembly regs + final beat) loads into output register at that edge; go IDLE.
//          Otherwise completed frame held in assembly register, go HOLD.
//    HOLD: in_ready=0; when output transfer occurs, assembly frame moves to output at that edge, go IDLE.
//  - Latency: frame_valid rises the cycle after the last-beat handshake when output is free.
//  - Throughput: one beat per cycle sustained; back-to-back frames with no gap when frame_ready=1.
//  - frame_llrs/hard_dec stable while frame_valid=1 and not transferred; frame_valid drops the cycle
//    after transfer unless a new frame loads at that same edge (then stays 1 with new data).
//  - frame_err registered: asserted one cycle after the offending beat, for exactly one cycle.
//  - Counter width $clog2(N_CHUNKS+1); no wrap beyond N_CHUNKS-1. Frames delivered in arrival order;
//    no frame dropped or duplicated under any frame_ready pattern.
// TESTING
//  1. N_V=31,N_LLRS=4: 8 beats, LLR i = i, lane 3 of beat 8 = 8'hFF -> frame_valid 1 cycle after
//     beat 8; frame_llrs[i*8+:8]==i for i<31; hard_dec==0.
//  2. frame_ready=1, 16 consecutive beats (two frames) -> in_ready stays 1; frame_valid high two
//     consecutive frame periods, data of frame 2 replaces frame 1 without gap or duplicate.
//  3. frame_ready=0; frames A then B -> after B's last beat in_ready=0 (HOLD); raise frame_ready ->
//     A delivered, then B next cycle; in_ready returns to 1.
//  4. in_first on beat 5 of a frame -> frame_err pulse; new frame of 8 beats completes, contains only
//     new data, exactly one frame_valid transfer.
//  5. IDLE, beat with in_valid=1,in_first=0 -> frame_err pulse, no frame_valid; all LLRs = -1 frame
//     then gives hard_dec = 31'h7FFFFFFF.
//  6. Assert rst asynchronously during beat 4 -> outputs 0 before next clk edge; after release a full
//     frame loads correctly. Repeat test 1 with N_V=3,N_LLRS=4 (single-beat frame).

Source files
------------

// File: rtl/llr_frame_loader.sv
// llr_frame_loader: deserialises one codeword of channel LLRs, delivered N_LLRS per beat,
// into a full frame. The frame is then presented with its hard decisions to the decoder core.
// Two frame registers form a ping-pong pair. The assembly register collects beats, and the
// output register holds the frame offered to the core, so the next frame can load while the
// current one waits.
//
// Handshakes (strict valid/ready): a beat moves when in_valid & in_ready on a rising edge, and
// a frame moves when frame_valid & frame_ready on a rising edge. A producer must hold its payload
// stable while valid is high and not yet accepted; the loader does this for frame_llrs/hard_dec.
module llr_frame_loader #(
  parameter int WIDTH  = 8,
  parameter int N_LLRS = 4,
  parameter int N_V    = 31
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_LLRS*WIDTH-1:0] in_llr,
  input  logic                    in_first,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [N_V*WIDTH-1:0]    frame_llrs,
  output logic [N_V-1:0]          hard_dec,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic                    frame_err
);

  localparam int N_CHUNKS = (N_V + N_LLRS - 1) / N_LLRS;
  localparam int CW       = $clog2(N_CHUNKS + 1);
  localparam int FW       = N_V * WIDTH;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(N_CHUNKS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [CW-1:0]   chunk_idx;
  logic [FW-1:0]   asm_q, asm_d;
  logic [FW-1:0]   out_q;
  logic            beat, out_xfer, out_free;
  logic            store, complete, out_load, err_d;

  assign in_ready   = (state != S_HOLD);
  assign beat       = in_valid & in_ready;
  assign out_xfer   = frame_valid & frame_ready;
  assign out_free   = ~frame_valid | frame_ready;
  // A first-flagged beat always lands as chunk 0, whether it starts or restarts a frame.
  assign chunk_idx  = in_first ? '0 : cnt;
  assign frame_llrs = out_q;

  // State register, chunk counter, assembly and output frame registers, error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      asm_q       <= '0;
      out_q       <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      asm_q     <= asm_d;
      frame_err <= err_d;
      if (out_load) begin
        out_q       <= asm_d;
        frame_valid <= 1'b1;
      end else if (out_xfer) begin
        frame_valid <= 1'b0;
      end
    end
  end

  // Next-state logic: beat acceptance, abort on a stray first beat, completion and handoff.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    store    = 1'b0;
    complete = 1'b0;
    err_d    = 1'b0;
    out_load = 1'b0;
    case (state)
      S_IDLE: begin
        if (beat) begin
          if (in_first) begin
            store = 1'b1;
            if (LAST_CHUNK == '0) begin
              complete = 1'b1;
            end else begin
              cnt_d   = CW'(1);
              state_d = S_LOAD;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (beat) begin
          store = 1'b1;
          if (in_first) begin
            err_d = 1'b1;
            if (LAST_CHUNK == '0) complete = 1'b1;
            else                  cnt_d    = CW'(1);
          end else if (cnt == LAST_CHUNK) begin
            complete = 1'b1;
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
      end
      S_HOLD: begin
        if (out_xfer) begin
          out_load = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (complete) begin
      cnt_d = '0;
      if (out_free) begin
        out_load = 1'b1;
        state_d  = S_IDLE;
      end else begin
        state_d = S_HOLD;
      end
    end
  end

  // Merge the accepted beat into the assembly frame; lanes past N_V in the last chunk drop out.
  always_comb begin
    asm_d = asm_q;
    for (int i = 0; i < N_V; i++) begin
      if (store && (int'(chunk_idx) == (i / N_LLRS))) begin
        asm_d[i*WIDTH +: WIDTH] = in_llr[(i % N_LLRS)*WIDTH +: WIDTH];
      end
    end
  end

  // Hard decision per LLR is its two's-complement sign bit.
  always_comb begin
    hard_dec = '0;
    for (int i = 0; i < N_V; i++) begin
      hard_dec[i] = out_q[i*WIDTH + WIDTH - 1];
    end
  end

endmodule
